// File: rtl/fpu_pkg.sv
// Shared FPU types: pre-normalization bundle handed from the arithmetic units to the normalizer.
package fpu_pkg;

  localparam int NORM_EXP_W  = 10;
  localparam int NORM_FRAC_W = 49;

  localparam int SRC_ADDSUB = 0;
  localparam int SRC_MUL    = 1;
  localparam int SRC_DIV    = 2;

  typedef struct packed {
    logic                   normalize;
    logic [NORM_EXP_W-1:0]  calculated_exponent;
    logic [NORM_EXP_W-1:0]  added_exponent;
    logic [NORM_EXP_W-1:0]  subtracted_exponent;
    logic [NORM_FRAC_W-1:0] calculated_fraction;
  } norm_req_t;

endpackage

// File: rtl/normalizer_arbiter_if.sv
// Requester-side and normalizer-side handshake bundle of the normalizer arbiter.
interface normalizer_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = 2
);
  import fpu_pkg::*;

  logic      [NUM_REQ-1:0] req_valid;
  norm_req_t [NUM_REQ-1:0] req_data;
  logic      [NUM_REQ-1:0] req_ready;
  logic                    out_valid;
  norm_req_t               out_data;
  logic      [SRC_W-1:0]   out_source;
  logic                    out_ready;

  modport master (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_source
  );

  modport slave (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_source
  );

endinterface

// File: rtl/normalizer_arb_grant.sv
// Combinational one-hot grant among valid requesters; NORMALIZER_ARB_ROUND_ROBIN_EN selects
// round-robin from last_grant+1, otherwise fixed priority with lowest index winning.
module normalizer_arb_grant #(
  parameter int NUM_REQ = 3
`ifdef NORMALIZER_ARB_ROUND_ROBIN_EN
  ,
  parameter int SRC_W   = 2
`endif
) (
  input  logic [NUM_REQ-1:0] req_valid,
`ifdef NORMALIZER_ARB_ROUND_ROBIN_EN
  input  logic [SRC_W-1:0]   last_grant,
`endif
  output logic [NUM_REQ-1:0] grant
);

`ifdef NORMALIZER_ARB_ROUND_ROBIN_EN
  logic found;

  // Walk offsets 1..NUM_REQ from the last winner; the first valid one takes the grant.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!found && req_valid[i] && (i == (int'(last_grant) + k) % NUM_REQ)) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end
`else
  always_comb begin
    grant = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/normalizer_arbiter.sv
// Shares the normalizer among add/sub, mul and div via a 2-entry buffer; accept-to-output 1 cycle.
// req_ready drops while the buffer is full; NORMALIZER_ARB_ROUND_ROBIN_EN picks round-robin arbitration.
module normalizer_arbiter
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int SRC_W   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  normalizer_arbiter_if.master bus,
  output logic                 busy
);

  logic [NUM_REQ-1:0] grant;
  logic [SRC_W-1:0]   grant_idx;
  logic [1:0]         count;
  logic               head;
  logic               tail;
  logic               rdy_en;
  logic               full;
  logic               push;
  logic               pop;
  norm_req_t          buf_data [2];
  logic [SRC_W-1:0]   buf_src  [2];

`ifdef NORMALIZER_ARB_ROUND_ROBIN_EN
  logic [SRC_W-1:0] last_grant;

  normalizer_arb_grant #(
    .NUM_REQ (NUM_REQ),
    .SRC_W   (SRC_W)
  ) u_grant (
    .req_valid  (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Only a completed transfer moves the pointer; a stalled grant keeps its priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= SRC_W'(NUM_REQ - 1);
    end else if (push) begin
      last_grant <= grant_idx;
    end
  end
`else
  normalizer_arb_grant #(
    .NUM_REQ (NUM_REQ)
  ) u_grant (
    .req_valid (bus.req_valid),
    .grant     (grant)
  );
`endif

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_idx = SRC_W'(i);
      end
    end
  end

  // rdy_en keeps req_ready low while reset is held even if requesters keep valid asserted.
  assign full          = (count == 2'd2);
  assign bus.req_ready = (rdy_en && !full) ? grant : '0;
  assign push          = |(bus.req_valid & bus.req_ready);
  assign bus.out_valid = (count != 2'd0);
  assign pop           = bus.out_valid & bus.out_ready;
  assign bus.out_data  = buf_data[head];
  assign bus.out_source = buf_src[head];
  assign busy          = bus.out_valid | (|bus.req_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      rdy_en <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (push) begin
        tail <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[tail] <= bus.req_data[grant_idx];
      buf_src[tail]  <= grant_idx;
    end
  end

endmodule
